// File: rtl/pkt_burst_rd.sv
// pkt_burst_rd: Avalon-MM burst read master copying one packet into the capture FIFO.
// Optional feature PKT_BURST_RD_BEATCNT_EN adds a 32-bit beat_count output.
module pkt_burst_rd #(
    parameter  int DATA_W    = 32,
    parameter  int ADDR_W    = 32,
    parameter  int BURST_LEN = 8,
    localparam int BYTES     = DATA_W / 8,
    localparam int BC_W      = $clog2(BURST_LEN) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] pkt_begin,
    input  logic [ADDR_W-1:0] pkt_end,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              fifo_almost_full,
    output logic              fifo_wr,
    output logic [DATA_W-1:0] fifo_data,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic [BC_W-1:0]   avm_burstcount,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid
`ifdef PKT_BURST_RD_BEATCNT_EN
    ,
    output logic [31:0]       beat_count
`endif
);

    localparam int              SHIFT   = $clog2(BYTES);
    localparam logic [ADDR_W:0] REM_ONE = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {IDLE, WAIT, REQ, DATA, DONE} state_t;

    state_t            state;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W:0]   rem_init;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_nx;
    logic [BC_W-1:0]   beats;

    function automatic logic [BC_W-1:0] burst_of(input logic [ADDR_W:0] rem);
        if (rem >= (ADDR_W+1)'(BURST_LEN))
            return BC_W'(BURST_LEN);
        return rem[BC_W-1:0];
    endfunction

    // remaining is one bit wider so a full-range packet still fits
    always_comb begin
        rem_init = {1'b0, (pkt_end - pkt_begin) >> SHIFT} + REM_ONE;
        addr_nx  = addr + (ADDR_W'(avm_burstcount) << SHIFT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            remaining      <= '0;
            addr           <= '0;
            beats          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            fifo_wr        <= 1'b0;
            fifo_data      <= '0;
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_burstcount <= '0;
`ifdef PKT_BURST_RD_BEATCNT_EN
            beat_count     <= '0;
`endif
        end else begin
            fifo_wr <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
`ifdef PKT_BURST_RD_BEATCNT_EN
                        beat_count <= '0;
`endif
                        if (pkt_end < pkt_begin) begin
                            done  <= 1'b1;
                            err   <= 1'b1;
                            state <= DONE;
                        end else begin
                            remaining <= rem_init;
                            addr      <= pkt_begin;
                            busy      <= 1'b1;
                            if (fifo_almost_full) begin
                                state <= WAIT;
                            end else begin
                                state          <= REQ;
                                avm_read       <= 1'b1;
                                avm_address    <= pkt_begin;
                                avm_burstcount <= burst_of(rem_init);
                            end
                        end
                    end
                end
                WAIT: begin
                    if (!fifo_almost_full) begin
                        state          <= REQ;
                        avm_read       <= 1'b1;
                        avm_address    <= addr;
                        avm_burstcount <= burst_of(remaining);
                    end
                end
                REQ: begin
                    if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        beats    <= avm_burstcount;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (beats != '0) begin
                        if (avm_readdatavalid) begin
                            fifo_wr   <= 1'b1;
                            fifo_data <= avm_readdata;
                            beats     <= beats - BC_W'(1);
                            remaining <= remaining - REM_ONE;
`ifdef PKT_BURST_RD_BEATCNT_EN
                            beat_count <= beat_count + 32'd1;
`endif
                        end
                    end else begin
                        // burst drained: this cycle also gives the idle gap on avm_read
                        addr <= addr_nx;
                        if (remaining == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else if (fifo_almost_full) begin
                            state <= WAIT;
                        end else begin
                            state          <= REQ;
                            avm_read       <= 1'b1;
                            avm_address    <= addr_nx;
                            avm_burstcount <= burst_of(remaining);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_burst_rd.sv
// tb_pkt_burst_rd: directed and randomized bench for pkt_burst_rd.
// Uses a behavioural Avalon slave and a chunking reference model.
module tb_pkt_burst_rd;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int BURST_LEN = 8;
    localparam int BC_W      = $clog2(BURST_LEN) + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] pkt_begin;
    logic [ADDR_W-1:0] pkt_end;
    logic              busy;
    logic              done;
    logic              err;
    logic              fifo_almost_full;
    logic              fifo_wr;
    logic [DATA_W-1:0] fifo_data;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic [BC_W-1:0]   avm_burstcount;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;
`ifdef PKT_BURST_RD_BEATCNT_EN
    logic [31:0]       beat_count;
`endif

    pkt_burst_rd #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .pkt_begin(pkt_begin), .pkt_end(pkt_end),
        .busy(busy), .done(done), .err(err),
        .fifo_almost_full(fifo_almost_full),
        .fifo_wr(fifo_wr), .fifo_data(fifo_data),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_burstcount(avm_burstcount),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid)
`ifdef PKT_BURST_RD_BEATCNT_EN
        , .beat_count(beat_count)
`endif
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int wr_cyc_last = 0;
    int rd_cnt = 0;
    int unstable = 0;
    int stall_seen = 0;
    int stall_first = -1;
    int stall_len = 0;
    bit gap_en = 1'b1;
    int wr_base, req_base, unst_base;
    logic [31:0] seed;
    logic [31:0] wr_q[$];
    logic [31:0] req_a_q[$];
    int          req_bc_q[$];
    logic [31:0] pend_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ seed;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // monitor: records FIFO writes and read-request cycles
    initial forever begin
        @(posedge clk); #1;
        cyc++;
        if (fifo_wr) begin
            wr_q.push_back(fifo_data);
            wr_cyc_last = cyc;
        end
        if (avm_read) rd_cnt++;
    end

    // behavioural Avalon slave with optional stall and random data gaps
    initial begin
        logic [31:0]     s_a;
        logic [BC_W-1:0] s_bc;
        bit              stalling;
        int              stall_cnt;
        stalling  = 1'b0;
        stall_cnt = 0;
        s_a  = '0;
        s_bc = '0;
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        forever begin
            @(posedge clk); #1;
            avm_readdatavalid = 1'b0;
            if (pend_q.size() > 0 && (!gap_en || $urandom_range(3) != 0)) begin
                avm_readdata      = mem_word(pend_q.pop_front());
                avm_readdatavalid = 1'b1;
            end
            avm_waitrequest = 1'b0;
            if (!avm_read) begin
                stalling = 1'b0;
            end else begin
                if (stalling) begin
                    if (avm_address !== s_a || avm_burstcount !== s_bc) unstable++;
                end else begin
                    s_a  = avm_address;
                    s_bc = avm_burstcount;
                end
                if (req_a_q.size() == stall_first && stall_cnt < stall_len) begin
                    avm_waitrequest = 1'b1;
                    stalling = 1'b1;
                    stall_cnt++;
                    stall_seen++;
                end else begin
                    stalling  = 1'b0;
                    stall_cnt = 0;
                    req_a_q.push_back(avm_address);
                    req_bc_q.push_back(int'(avm_burstcount));
                    for (int i = 0; i < int'(avm_burstcount); i++)
                        pend_q.push_back(avm_address + 32'(4 * i));
                end
            end
        end
    end

    task automatic start_xfer(input logic [31:0] b, input logic [31:0] e);
        wr_base   = wr_q.size();
        req_base  = req_a_q.size();
        unst_base = unstable;
        pkt_begin = b;
        pkt_end   = e;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("lat_read", 64'(avm_read), 64'd1);
        chk("lat_addr", 64'(avm_address), 64'(b));
        chk("lat_busy", 64'(busy), 64'd1);
    endtask

    task automatic finish_xfer(input logic [31:0] b, input logic [31:0] e, input string tag);
        int n, k, lim, rem, bc;
        logic [31:0] a;
        lim = 0;
        while (!done && lim < 3000) begin
            @(negedge clk);
            lim++;
        end
        chk({tag, ".done"}, 64'(done), 64'd1);
        chk({tag, ".err"}, 64'(err), 64'd0);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".done_lat"}, 64'(cyc - wr_cyc_last), 64'd1);
        n = int'((e - b) >> 2) + 1;
        chk({tag, ".nwr"}, 64'(wr_q.size() - wr_base), 64'(n));
        for (int i = 0; i < n; i++)
            if (wr_base + i < wr_q.size())
                chk({tag, ".data"}, 64'(wr_q[wr_base + i]), 64'(mem_word(b + 32'(4 * i))));
        a = b;
        rem = n;
        k = 0;
        while (rem > 0) begin
            bc = (rem > BURST_LEN) ? BURST_LEN : rem;
            if (req_base + k < req_a_q.size()) begin
                chk({tag, ".req_addr"}, 64'(req_a_q[req_base + k]), 64'(a));
                chk({tag, ".req_bc"}, 64'(req_bc_q[req_base + k]), 64'(bc));
            end
            a = a + 32'(bc * 4);
            rem = rem - bc;
            k++;
        end
        chk({tag, ".nreq"}, 64'(req_a_q.size() - req_base), 64'(k));
        chk({tag, ".stable"}, 64'(unstable - unst_base), 64'd0);
`ifdef PKT_BURST_RD_BEATCNT_EN
        chk({tag, ".beats"}, 64'(beat_count), 64'(n));
`endif
        @(negedge clk);
        chk({tag, ".pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int lim, r0, s0, w0;
        reset = 1'b0;
        start = 1'b0;
        pkt_begin = '0;
        pkt_end = '0;
        fifo_almost_full = 1'b0;
        seed = 32'h5a3c_0f00 ^ $urandom;
        repeat (3) @(negedge clk);
        chk("rst_ctl", 64'({busy, done, err, fifo_wr, avm_read}), 64'd0);
        chk("rst_data", 64'(fifo_data), 64'd0);
        chk("rst_avm", 64'({avm_burstcount, avm_address}), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        start_xfer(32'h1000, 32'h101C);
        finish_xfer(32'h1000, 32'h101C, "single");

        start_xfer(32'h1000, 32'h1040);
        finish_xfer(32'h1000, 32'h1040, "split");

        s0 = stall_seen;
        stall_first = req_a_q.size();
        stall_len = 3;
        start_xfer(32'h1000, 32'h101C);
        finish_xfer(32'h1000, 32'h101C, "wreq");
        chk("wreq.stalls", 64'(stall_seen - s0), 64'd3);

        start_xfer(32'h4000, 32'h403C);
        lim = 0;
        while (wr_q.size() - wr_base < 8 && lim < 200) begin
            @(negedge clk);
            lim++;
        end
        chk("bp.first_burst", 64'(wr_q.size() - wr_base), 64'd8);
        fifo_almost_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp.hold", 64'(avm_read), 64'd0);
        end
        fifo_almost_full = 1'b0;
        @(negedge clk);
        chk("bp.issue", 64'(avm_read), 64'd1);
        chk("bp.addr", 64'(avm_address), 64'h4020);
        finish_xfer(32'h4000, 32'h403C, "bp");

        r0 = rd_cnt;
        pkt_begin = 32'h2000;
        pkt_end = 32'h1FFC;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("inv.done", 64'(done), 64'd1);
        chk("inv.err", 64'(err), 64'd1);
        chk("inv.busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("inv.pulse", 64'({done, err}), 64'd0);
        repeat (3) @(negedge clk);
        chk("inv.noread", 64'(rd_cnt - r0), 64'd0);

        start_xfer(32'h3000, 32'h301C);
        lim = 0;
        while (wr_q.size() - wr_base < 3 && lim < 200) begin
            @(negedge clk);
            lim++;
        end
        chk("rstmid.beats", 64'(wr_q.size() - wr_base), 64'd3);
        reset = 1'b0;
        w0 = wr_q.size();
        @(negedge clk);
        chk("rstmid.ctl", 64'({busy, done, err, fifo_wr, avm_read}), 64'd0);
        chk("rstmid.data", 64'(fifo_data), 64'd0);
        chk("rstmid.avm", 64'({avm_burstcount, avm_address}), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        lim = 0;
        while (pend_q.size() > 0 && lim < 100) begin
            @(negedge clk);
            lim++;
        end
        @(negedge clk);
        chk("rstmid.ignored", 64'(wr_q.size() - w0), 64'd0);
        start_xfer(32'h3000, 32'h301C);
        finish_xfer(32'h3000, 32'h301C, "after_rst");

        for (int t = 0; t < 6; t++) begin
            logic [31:0] b, e;
            int len;
            b = 32'h0001_0000 + {16'd0, 14'($urandom), 2'b00};
            len = (t == 0) ? 1 : ((t == 1) ? BURST_LEN + 1 : int'($urandom_range(1, 40)));
            e = b + 32'(4 * (len - 1));
            gap_en = 1'($urandom);
            stall_first = req_a_q.size() + int'($urandom_range(0, 2));
            stall_len = int'($urandom_range(0, 3));
            start_xfer(b, e);
            finish_xfer(b, e, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
